// File: rtl/spi_accel_responder_if.sv
// SPI bus between the accelerometer master and the emulated sensor.
interface spi_accel_responder_if;
  logic SCL;
  logic CS;
  logic MOSI;
  logic MISO;

  modport master (output SCL, output CS, output MOSI, input MISO);
  modport slave  (input SCL, input CS, input MOSI, output MISO);
endinterface

// File: rtl/spi_accel_responder.sv
// SPI mode-3 slave emulating a three-axis accelerometer register map,
// oversampling the SPI pins in sys_clock and serving samples from a parallel port.
module spi_accel_responder #(
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h33,
  parameter logic [7:0] CTRL_REG1_RST = 8'h07,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                sys_clock,
  input  logic                reset,
  spi_accel_responder_if.slave spi,
  input  logic                sample_valid,
  input  logic signed [15:0]  sample_x,
  input  logic signed [15:0]  sample_y,
  input  logic signed [15:0]  sample_z,
  output logic [7:0]          ctrl_reg1,
  output logic [7:0]          ctrl_reg4,
  output logic                data_ready,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [SYNC_STAGES-1:0] scl_sync, cs_sync, mosi_sync;
  logic       scl_prev, cs_prev;
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic       rw, ms;
  logic [5:0] addr;
  logic       miso_q;
  logic [7:0] ctrl_regs [6];
  logic [15:0] x_live, y_live, z_live;
  logic [15:0] snap_x, snap_y, snap_z;
  logic       zyxda, zyxor;
  logic [7:0] snap_status;

  logic       scl_s, cs_s, mosi_s;
  logic       scl_rise, scl_fall, cs_rise, cs_fall;
  logic [7:0] rx_byte;
  logic       byte_done, clear_status;
  logic [5:0] next_addr;

  // Synchronizers idle at the bus idle levels so reset never fakes an edge.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      scl_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], spi.SCL};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
    end
  end

  assign scl_s        = scl_sync[SYNC_STAGES-1];
  assign cs_s         = cs_sync[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync[SYNC_STAGES-1];
  assign scl_rise     = scl_s & ~scl_prev;
  assign scl_fall     = ~scl_s & scl_prev;
  assign cs_rise      = cs_s & ~cs_prev;
  assign cs_fall      = ~cs_s & cs_prev;
  assign rx_byte      = {shift_in, mosi_s};
  assign byte_done    = scl_rise && (bit_cnt == 3'd7) && !cs_rise;
  assign clear_status = byte_done && (state == DATA) && rw && (addr == 6'h2D);
  assign next_addr    = ms ? addr + 6'd1 : addr;

  // Reads see only the snapshot taken at frame start, keeping a burst coherent.
  function automatic logic [7:0] read_map(input logic [5:0] a);
    case (a)
      6'h0F:   read_map = WHO_AM_I_VAL;
      6'h20:   read_map = ctrl_regs[0];
      6'h21:   read_map = ctrl_regs[1];
      6'h22:   read_map = ctrl_regs[2];
      6'h23:   read_map = ctrl_regs[3];
      6'h24:   read_map = ctrl_regs[4];
      6'h25:   read_map = ctrl_regs[5];
      6'h27:   read_map = snap_status;
      6'h28:   read_map = snap_x[7:0];
      6'h29:   read_map = snap_x[15:8];
      6'h2A:   read_map = snap_y[7:0];
      6'h2B:   read_map = snap_y[15:8];
      6'h2C:   read_map = snap_z[7:0];
      6'h2D:   read_map = snap_z[15:8];
      default: read_map = 8'h00;
    endcase
  endfunction

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      scl_prev    <= 1'b1;
      cs_prev     <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift_in    <= 7'd0;
      shift_out   <= 8'd0;
      rw          <= 1'b0;
      ms          <= 1'b0;
      addr        <= 6'd0;
      miso_q      <= 1'b0;
      for (int i = 0; i < 6; i++) ctrl_regs[i] <= (i == 0) ? CTRL_REG1_RST : 8'h00;
      x_live      <= 16'd0;
      y_live      <= 16'd0;
      z_live      <= 16'd0;
      snap_x      <= 16'd0;
      snap_y      <= 16'd0;
      snap_z      <= 16'd0;
      zyxda       <= 1'b0;
      zyxor       <= 1'b0;
      snap_status <= 8'd0;
    end else begin
      scl_prev <= scl_s;
      cs_prev  <= cs_s;

      // A new sample beats a simultaneous read-clear of the status flags.
      if (sample_valid) begin
        x_live <= sample_x;
        y_live <= sample_y;
        z_live <= sample_z;
        zyxda  <= 1'b1;
        if (zyxda || clear_status) zyxor <= 1'b1;
      end else if (clear_status) begin
        zyxda <= 1'b0;
        zyxor <= 1'b0;
      end

      if (cs_rise) begin
        state   <= IDLE;
        miso_q  <= 1'b0;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state       <= CMD;
              bit_cnt     <= 3'd0;
              snap_x      <= x_live;
              snap_y      <= y_live;
              snap_z      <= z_live;
              snap_status <= {zyxor, 3'b000, zyxda, 3'b000};
            end
          end
          CMD: begin
            miso_q <= 1'b0;
            if (scl_rise) begin
              shift_in <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (byte_done) begin
                rw        <= rx_byte[7];
                ms        <= rx_byte[6];
                addr      <= rx_byte[5:0];
                shift_out <= read_map(rx_byte[5:0]);
                state     <= DATA;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shift_in <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (!rw && addr >= 6'h20 && addr <= 6'h25)
                  ctrl_regs[3'(addr - 6'h20)] <= rx_byte;
                addr <= next_addr;
                if (rw) shift_out <= read_map(next_addr);
              end
            end else if (scl_fall && rw) begin
              miso_q    <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi.MISO   = miso_q;
  assign ctrl_reg1  = ctrl_regs[0];
  assign ctrl_reg4  = ctrl_regs[3];
  assign data_ready = zyxda;
  assign busy       = ~cs_s;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder acting as an SPI mode-3 master.
module tb_spi_accel_responder;

  logic        sys_clock;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;
  logic [7:0]  ctrl_reg1, ctrl_reg4;
  logic        data_ready, busy;
  int          pass_count;
  int          check_count;

  spi_accel_responder_if spi_bus ();

  spi_accel_responder dut (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .spi          (spi_bus),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .ctrl_reg1    (ctrl_reg1),
    .ctrl_reg4    (ctrl_reg4),
    .data_ready   (data_ready),
    .busy         (busy)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic cs_low();
    spi_bus.CS = 1'b0;
    wait_cycles(8);
  endtask

  task automatic cs_high();
    spi_bus.SCL = 1'b1;
    wait_cycles(8);
    spi_bus.CS = 1'b1;
    wait_cycles(8);
  endtask

  // Mode 3: drive MOSI on the falling edge, capture MISO just before the rise.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_bus.SCL  = 1'b0;
      spi_bus.MOSI = tx[i];
      wait_cycles(8);
      rx[i] = spi_bus.MISO;
      spi_bus.SCL = 1'b1;
      wait_cycles(8);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  // Last rising edge timed so the sample strobe lands on the byte-complete cycle.
  task automatic xfer_byte_collide(input logic [7:0] tx, input logic [15:0] z_new,
                                   output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_bus.SCL  = 1'b0;
      spi_bus.MOSI = tx[i];
      wait_cycles(8);
      rx[i] = spi_bus.MISO;
      spi_bus.SCL = 1'b1;
      if (i == 0) begin
        wait_cycles(2);
        sample_z     = z_new;
        sample_valid = 1'b1;
        wait_cycles(1);
        sample_valid = 1'b0;
        wait_cycles(5);
      end else begin
        wait_cycles(8);
      end
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x     = x;
    sample_y     = y;
    sample_z     = z;
    sample_valid = 1'b1;
    wait_cycles(1);
    sample_valid = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(2);
    check_count++;
    if (ctrl_reg1 !== 8'h07) $display("[TB] FAIL reset_ctrl1: got %h expected 07", ctrl_reg1);
    else pass_count++;
    check_count++;
    if (ctrl_reg4 !== 8'h00) $display("[TB] FAIL reset_ctrl4: got %h expected 00", ctrl_reg4);
    else pass_count++;
    check_count++;
    if (data_ready !== 1'b0) $display("[TB] FAIL reset_drdy: got %b expected 0", data_ready);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (spi_bus.MISO !== 1'b0) $display("[TB] FAIL reset_miso: got %b expected 0", spi_bus.MISO);
    else pass_count++;
  endtask

  task automatic test_write_ctrl();
    logic [7:0] rx;
    cs_low();
    check_count++;
    if (busy !== 1'b1) $display("[TB] FAIL busy_in_frame: got %b expected 1", busy);
    else pass_count++;
    xfer_byte(8'h20, rx);
    xfer_byte(8'h2F, rx);
    cs_high();
    cs_low(); xfer_byte(8'h23, rx); xfer_byte(8'hA5, rx); cs_high();
    check_count++;
    if (ctrl_reg4 !== 8'hA5) $display("[TB] FAIL write_ctrl4_a5: got %h expected a5", ctrl_reg4);
    else pass_count++;
    cs_low(); xfer_byte(8'h23, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (ctrl_reg1 !== 8'h2F) $display("[TB] FAIL write_ctrl1: got %h expected 2f", ctrl_reg1);
    else pass_count++;
    check_count++;
    if (ctrl_reg4 !== 8'h00) $display("[TB] FAIL write_ctrl4: got %h expected 00", ctrl_reg4);
    else pass_count++;
    cs_low(); xfer_byte(8'hA0, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (rx !== 8'h2F) $display("[TB] FAIL read_ctrl1: got %h expected 2f", rx);
    else pass_count++;
    cs_low(); xfer_byte(8'hA3, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (rx !== 8'h00) $display("[TB] FAIL read_ctrl4: got %h expected 00", rx);
    else pass_count++;
  endtask

  task automatic test_who_am_i();
    logic [7:0] rx;
    cs_low();
    xfer_byte(8'h8F, rx);
    check_count++;
    if (rx !== 8'h00) $display("[TB] FAIL cmd_miso_zero: got %h expected 00", rx);
    else pass_count++;
    xfer_byte(8'h00, rx);
    check_count++;
    if (rx !== 8'h33) $display("[TB] FAIL who_am_i: got %h expected 33", rx);
    else pass_count++;
    cs_high();
    check_count++;
    if (spi_bus.MISO !== 1'b0) $display("[TB] FAIL miso_after_cs: got %b expected 0", spi_bus.MISO);
    else pass_count++;
  endtask

  task automatic test_sample_read();
    logic [7:0] rx;
    logic [7:0] exp_bytes [7] = '{8'h08, 8'h34, 8'h12, 8'h80, 8'hFF, 8'h01, 8'h00};
    pulse_sample(16'h1234, 16'hFF80, 16'h0001);
    check_count++;
    if (data_ready !== 1'b1) $display("[TB] FAIL drdy_set: got %b expected 1", data_ready);
    else pass_count++;
    cs_low();
    xfer_byte(8'hE7, rx);
    for (int b = 0; b < 7; b++) begin
      xfer_byte(8'h00, rx);
      check_count++;
      if (rx !== exp_bytes[b]) $display("[TB] FAIL burst_byte%0d: got %h expected %h", b, rx, exp_bytes[b]);
      else pass_count++;
    end
    cs_high();
    check_count++;
    if (data_ready !== 1'b0) $display("[TB] FAIL drdy_clear: got %b expected 0", data_ready);
    else pass_count++;
  endtask

  task automatic test_overrun();
    logic [7:0] rx;
    pulse_sample(16'h0001, 16'h0002, 16'h0003);
    pulse_sample(16'h1111, 16'h2222, 16'h7700);
    cs_low(); xfer_byte(8'hA7, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (rx !== 8'h88) $display("[TB] FAIL status_overrun: got %h expected 88", rx);
    else pass_count++;
    cs_low();
    xfer_byte(8'hAD, rx);
    xfer_byte_collide(8'h00, 16'h5500, rx);
    cs_high();
    check_count++;
    if (rx !== 8'h77) $display("[TB] FAIL snapshot_zh: got %h expected 77", rx);
    else pass_count++;
    check_count++;
    if (data_ready !== 1'b1) $display("[TB] FAIL set_wins: got %b expected 1", data_ready);
    else pass_count++;
    cs_low(); xfer_byte(8'hAD, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (rx !== 8'h55) $display("[TB] FAIL next_frame_zh: got %h expected 55", rx);
    else pass_count++;
    check_count++;
    if (data_ready !== 1'b0) $display("[TB] FAIL drdy_clear2: got %b expected 0", data_ready);
    else pass_count++;
  endtask

  task automatic test_partial_and_wrap();
    logic [7:0] rx;
    logic [7:0] first_rx;
    cs_low(); xfer_byte(8'h20, rx); xfer_bits(8'hC3, 5, rx); cs_high();
    check_count++;
    if (ctrl_reg1 !== 8'h2F) $display("[TB] FAIL partial_ctrl1: got %h expected 2f", ctrl_reg1);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL partial_busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (spi_bus.MISO !== 1'b0) $display("[TB] FAIL partial_miso: got %b expected 0", spi_bus.MISO);
    else pass_count++;
    cs_low(); xfer_byte(8'hA0, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (rx !== 8'h2F) $display("[TB] FAIL after_partial_read: got %h expected 2f", rx);
    else pass_count++;
    cs_low(); xfer_byte(8'h23, rx); xfer_byte(8'h12, rx); xfer_byte(8'h34, rx); cs_high();
    check_count++;
    if (ctrl_reg4 !== 8'h34) $display("[TB] FAIL ms0_hold: got %h expected 34", ctrl_reg4);
    else pass_count++;
    cs_low();
    xfer_byte(8'h7F, rx);
    xfer_byte(8'h99, rx); xfer_byte(8'h98, rx); xfer_byte(8'h97, rx);
    cs_high();
    check_count++;
    if (ctrl_reg1 !== 8'h2F) $display("[TB] FAIL wrap_write_ctrl1: got %h expected 2f", ctrl_reg1);
    else pass_count++;
    check_count++;
    if (ctrl_reg4 !== 8'h34) $display("[TB] FAIL wrap_write_ctrl4: got %h expected 34", ctrl_reg4);
    else pass_count++;
    cs_low();
    xfer_byte(8'hFF, rx);
    xfer_byte(8'h00, first_rx);
    for (int b = 1; b < 17; b++) xfer_byte(8'h00, rx);
    cs_high();
    check_count++;
    if (first_rx !== 8'h00) $display("[TB] FAIL wrap_read_3f: got %h expected 00", first_rx);
    else pass_count++;
    check_count++;
    if (rx !== 8'h33) $display("[TB] FAIL wrap_read_0f: got %h expected 33", rx);
    else pass_count++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx;
    pulse_sample(16'hCAFE, 16'hBEEF, 16'h1357);
    cs_low();
    xfer_byte(8'hE8, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h00, rx);
    xfer_bits(8'h00, 3, rx);
    reset = 1'b1;
    wait_cycles(1);
    check_count++;
    if (ctrl_reg1 !== 8'h07) $display("[TB] FAIL mid_reset_ctrl1: got %h expected 07", ctrl_reg1);
    else pass_count++;
    check_count++;
    if (ctrl_reg4 !== 8'h00) $display("[TB] FAIL mid_reset_ctrl4: got %h expected 00", ctrl_reg4);
    else pass_count++;
    check_count++;
    if (data_ready !== 1'b0) $display("[TB] FAIL mid_reset_drdy: got %b expected 0", data_ready);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (spi_bus.MISO !== 1'b0) $display("[TB] FAIL mid_reset_miso: got %b expected 0", spi_bus.MISO);
    else pass_count++;
    spi_bus.SCL = 1'b1;
    spi_bus.CS  = 1'b1;
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(8);
    cs_low(); xfer_byte(8'h8F, rx); xfer_byte(8'h00, rx); cs_high();
    check_count++;
    if (rx !== 8'h33) $display("[TB] FAIL post_reset_who: got %h expected 33", rx);
    else pass_count++;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pass_count   = 0;
    check_count  = 0;
    reset        = 1'b1;
    spi_bus.SCL  = 1'b1;
    spi_bus.CS   = 1'b1;
    spi_bus.MOSI = 1'b0;
    sample_valid = 1'b0;
    sample_x     = 16'h0000;
    sample_y     = 16'h0000;
    sample_z     = 16'h0000;
    test_reset();
    test_write_ctrl();
    test_who_am_i();
    test_sample_read();
    test_overrun();
    test_partial_and_wrap();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
